// File: rtl/onecount_sched_if.sv
// onecount_sched_if
//   Bundles the client-side request/grant/ack signals and the engine-side
//   drive/status signals of the one-count scheduler.
//   slave  : scheduler view (requests and engine status in, grants/acks/engine controls out)
//   master : environment view (clients plus engine)
//   Ports:
//     i_req[N], i_data[N*W]        client requests and words
//     o_gnt[N], o_ack[N]           one-hot grant, one-cycle ack
//     o_result[W], o_err           count returned to the winner, timeout flag
//     o_busy                       scheduler not idle
//     o_engData[W], o_engRst_      word and active-low clear to the engine
//     i_engDone, i_engCount[W]     engine done level and count
interface onecount_sched_if #(
  parameter int N = 4,
  parameter int W = 16
);
  logic [N-1:0]   i_req;
  logic [N*W-1:0] i_data;
  logic [N-1:0]   o_gnt;
  logic [N-1:0]   o_ack;
  logic [W-1:0]   o_result;
  logic           o_err;
  logic           o_busy;
  logic [W-1:0]   o_engData;
  logic           o_engRst_;
  logic           i_engDone;
  logic [W-1:0]   i_engCount;

  modport slave (
    input  i_req, i_data, i_engDone, i_engCount,
    output o_gnt, o_ack, o_result, o_err, o_busy, o_engData, o_engRst_
  );

  modport master (
    output i_req, i_data, i_engDone, i_engCount,
    input  o_gnt, o_ack, o_result, o_err, o_busy, o_engData, o_engRst_
  );
endinterface

// File: rtl/onecount_sched.sv
// onecount_sched
//   Round-robin scheduler sharing one one-counter engine among N requesters.
//   Grants one requester, captures its word, sequences the engine through
//   clear/run, and returns the count with a one-cycle ack. A watchdog aborts a
//   run that never reports done, returning all ones with o_err set.
//   Ports:
//     i_clk   clock, rising edge
//     i_rst_  asynchronous active-low reset
//     bus     onecount_sched_if.slave (requests, grants, acks, engine link)
//
//   state   | meaning
//   IDLE    | engine held cleared, waiting for any request
//   CLEAR   | winner granted, engine cleared for one cycle, watchdog zeroed
//   RUN     | engine counting; wait for done or watchdog expiry
//   REPLY   | one-cycle ack to the winner, pointer advances past winner
module onecount_sched #(
  parameter int N       = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 40
) (
  input  logic              i_clk,
  input  logic              i_rst_,
  onecount_sched_if.slave   bus
);

  localparam int PW  = $clog2(N);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_REPLY} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   win_q;
  logic [W-1:0]    dat_q;
  logic [WDW-1:0]  wd_q;
  logic [W-1:0]    result_q;
  logic            err_q;

  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   scan_idx;
  logic            run_exit;
  logic [N-1:0]    win_onehot;

  // First set request scanning from ptr upward, wrapping modulo N.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int i = 0; i < N; i++) begin
      scan_idx = PW'((int'(ptr_q) + i) % N);
      if (!pick_found && bus.i_req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  assign run_exit = bus.i_engDone || (wd_q == WD_LAST);

  always_ff @(posedge i_clk or negedge i_rst_) begin
    if (!i_rst_) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pick_found) state_d = S_CLEAR;
      S_CLEAR: state_d = S_RUN;
      S_RUN:   if (run_exit) state_d = S_REPLY;
      S_REPLY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_) begin
    if (!i_rst_) begin
      ptr_q    <= '0;
      win_q    <= '0;
      dat_q    <= '0;
      wd_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_found) begin
            win_q <= pick_idx;
            dat_q <= bus.i_data[int'(pick_idx)*W +: W];
          end
        end
        S_CLEAR: wd_q <= '0;
        S_RUN: begin
          // Done wins over a simultaneous watchdog expiry.
          if (bus.i_engDone) begin
            result_q <= bus.i_engCount;
            err_q    <= 1'b0;
          end else if (wd_q == WD_LAST) begin
            result_q <= '1;
            err_q    <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_REPLY: ptr_q <= (int'(win_q) == N - 1) ? '0 : win_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign win_onehot    = {{(N-1){1'b0}}, 1'b1} << win_q;
  assign bus.o_gnt     = (state_q != S_IDLE) ? win_onehot : '0;
  assign bus.o_ack     = (state_q == S_REPLY) ? win_onehot : '0;
  assign bus.o_busy    = (state_q != S_IDLE);
  assign bus.o_engRst_ = (state_q == S_RUN) || (state_q == S_REPLY);
  // dat_q only changes on a grant edge, so the engine word is stable across CLEAR and RUN.
  assign bus.o_engData = dat_q;
  assign bus.o_result  = result_q;
  assign bus.o_err     = err_q;

endmodule

// File: tb/tb_onecount_sched.sv
module tb_onecount_sched;
  localparam int N = 4;
  localparam int W = 16;
  localparam int TIMEOUT = 40;

  logic clk;
  logic rst_;
  int   n_vec = 0;
  int   n_err = 0;

  onecount_sched_if #(.N(N), .W(W)) bus ();
  onecount_sched #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk (clk),
    .i_rst_(rst_),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- environment: clients + engine ----------------
  logic [N-1:0] req;
  logic [W-1:0] dval [N];
  logic         stuck = 1'b0;
  int           fixed_lat = -1;
  bit           auto_drop = 1'b1;
  bit           random_mode = 1'b0;
  int           run_cnt = 0;
  int           lat = 0;
  logic [N-1:0] ack_snap;

  always_comb begin
    bus.i_req = req;
    for (int k = 0; k < N; k++) bus.i_data[k*W +: W] = dval[k];
  end

  // Engine: cleared while o_engRst_ low; reports popcount of its word after lat+1 run cycles.
  initial begin
    req = '0;
    for (int k = 0; k < N; k++) dval[k] = '0;
    bus.i_engDone  = 1'b0;
    bus.i_engCount = '0;
    forever begin
      @(negedge clk) ack_snap = bus.o_ack;
      @(posedge clk);
      #1;
      if (!bus.o_engRst_) begin
        run_cnt = 0;
        lat = stuck ? 100000 : (fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, W + 3)));
      end else begin
        run_cnt++;
      end
      bus.i_engDone  = bus.o_engRst_ && (run_cnt > lat);
      bus.i_engCount = bus.i_engDone ? W'($countones(bus.o_engData)) : W'($urandom);
      if (auto_drop) req = req & ~ack_snap;
      if (random_mode) begin
        for (int k = 0; k < N; k++) begin
          if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
              0: dval[k] = '0;
              1: dval[k] = '1;
              default: dval[k] = W'($urandom);
            endcase
          end
          if (!req[k] && $urandom_range(0, 3) == 0) req[k] = 1'b1;
          else if (req[k] && bus.o_gnt[k] && $urandom_range(0, 15) == 0) req[k] = 1'b0;
        end
      end
    end
  end

  // ---------------- behavioural model ----------------
  // Service described by how far it has progressed: 0 idle, 1 clear cycle,
  // 2 counting run cycles, 3 reply cycle.
  bit           m_busy;
  int           m_phase, m_runs, m_ptr, m_win;
  logic [W-1:0] m_dat, m_result;
  logic         m_err;

  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      m_busy = 0; m_phase = 0; m_runs = 0; m_ptr = 0; m_win = 0;
      m_dat = '0; m_result = '0; m_err = 1'b0;
    end else if (m_phase == 0) begin
      if (bus.i_req != '0) begin
        for (int off = N - 1; off >= 0; off--)
          if (bus.i_req[(m_ptr + off) % N]) m_win = (m_ptr + off) % N;
        m_dat = dval[m_win];
        m_busy = 1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2; m_runs = 0;
    end else if (m_phase == 2) begin
      m_runs++;
      if (bus.i_engDone) begin
        m_result = W'($countones(m_dat)); m_err = 1'b0; m_phase = 3;
      end else if (m_runs == TIMEOUT) begin
        m_result = '1; m_err = 1'b1; m_phase = 3;
      end
    end else begin
      m_ptr = (m_win + 1) % N;
      m_busy = 0; m_phase = 0;
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] one, e_gnt, e_ack;
    one   = 1;
    e_gnt = m_busy ? (one << m_win) : '0;
    e_ack = (m_phase == 3) ? (one << m_win) : '0;
    chk("gnt",    32'(bus.o_gnt), 32'(e_gnt));
    chk("ack",    32'(bus.o_ack), 32'(e_ack));
    chk("busy",   32'(bus.o_busy), 32'(m_busy));
    chk("engRst", 32'(bus.o_engRst_), 32'(m_phase >= 2));
    chk("result", 32'(bus.o_result), 32'(m_result));
    chk("err",    32'(bus.o_err), 32'(m_err));
    if (m_phase == 1 || m_phase == 2 || !rst_) chk("engData", 32'(bus.o_engData), 32'(m_dat));
  end

  // ---------------- directed helpers ----------------
  task automatic apply_reset();
    @(posedge clk); #2;
    rst_ = 1'b0; req = '0;
    repeat (2) @(posedge clk);
    #2 rst_ = 1'b1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (bus.o_gnt == '0 && n < 200);
    if (n >= 200) chk("grant_timeout", 32'(bus.o_gnt), 32'hFFFF_FFFF);
  endtask

  task automatic wait_ack(output int n, output logic [N-1:0] a);
    n = 0;
    do begin @(negedge clk); n++; end while (bus.o_ack == '0 && n < 200);
    a = bus.o_ack;
    if (n >= 200) chk("ack_timeout", 32'(bus.o_ack), 32'hFFFF_FFFF);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    logic [N-1:0] a;
    logic [N-1:0] seq_exp [5];
    seq_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_ = 1'b0;

    // Reset with all requests high
    #2 req = 4'b1111;
    repeat (3) @(negedge clk);
    chk("rst_gnt",    32'(bus.o_gnt), 32'h0);
    chk("rst_ack",    32'(bus.o_ack), 32'h0);
    chk("rst_busy",   32'(bus.o_busy), 32'h0);
    chk("rst_engRst", 32'(bus.o_engRst_), 32'h0);
    chk("rst_result", 32'(bus.o_result), 32'h0);
    chk("rst_engData",32'(bus.o_engData), 32'h0);
    @(posedge clk); #2 rst_ = 1'b1;
    wait_grant(n);
    chk("first_grant", 32'(bus.o_gnt), 32'h1);

    // Single request: 0x00FF, done on the 18th run cycle
    apply_reset();
    fixed_lat = 17;
    @(posedge clk); #2 dval[0] = 16'h00FF; req = 4'b0001;
    wait_grant(n);
    wait_ack(n, a);
    chk("single_ack", 32'(a), 32'h1);
    chk("single_lat", 32'(n), 32'd19);
    chk("single_res", 32'(bus.o_result), 32'd8);
    chk("single_err", 32'(bus.o_err), 32'd0);

    // Simultaneous requests 0 and 2
    apply_reset();
    fixed_lat = -1;
    @(posedge clk); #2 dval[0] = 16'hFFFF; dval[2] = 16'h0001; req = 4'b0101;
    wait_ack(n, a);
    chk("sim_ack0", 32'(a), 32'h1);
    chk("sim_res0", 32'(bus.o_result), 32'd16);
    wait_ack(n, a);
    chk("sim_ack2", 32'(a), 32'h4);
    chk("sim_res2", 32'(bus.o_result), 32'd1);

    // Round robin with all requests held
    apply_reset();
    auto_drop = 1'b0;
    @(posedge clk); #2 req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      wait_ack(n, a);
      chk("rr_order", 32'(a), 32'(seq_exp[s]));
    end
    @(posedge clk); #2 req = '0; auto_drop = 1'b1;
    repeat (30) @(negedge clk);

    // Timeout, then a normal service
    apply_reset();
    stuck = 1'b1;
    @(posedge clk); #2 dval[1] = 16'h1234; req = 4'b0010;
    wait_grant(n);
    wait_ack(n, a);
    chk("to_ack", 32'(a), 32'h2);
    chk("to_lat", 32'(n), 32'd41);
    chk("to_res", 32'(bus.o_result), 32'hFFFF);
    chk("to_err", 32'(bus.o_err), 32'd1);
    stuck = 1'b0; fixed_lat = 3;
    @(posedge clk); #2 dval[1] = 16'h0003; req = 4'b0010;
    wait_ack(n, a);
    chk("after_to_res", 32'(bus.o_result), 32'd2);
    chk("after_to_err", 32'(bus.o_err), 32'd0);

    // Reset mid-run: pointer must return to 0
    apply_reset();
    fixed_lat = 2;
    @(posedge clk); #2 dval[0] = 16'h0005; req = 4'b0001;
    wait_ack(n, a);
    stuck = 1'b1;
    @(posedge clk); #2 dval[2] = 16'h00F0; req = 4'b0100;
    wait_grant(n);
    repeat (5) @(negedge clk);
    @(posedge clk); #2 rst_ = 1'b0; req = '0;
    @(negedge clk);
    chk("mid_rst_ack",    32'(bus.o_ack), 32'h0);
    chk("mid_rst_gnt",    32'(bus.o_gnt), 32'h0);
    chk("mid_rst_busy",   32'(bus.o_busy), 32'h0);
    chk("mid_rst_result", 32'(bus.o_result), 32'h0);
    @(posedge clk); #2 rst_ = 1'b1; stuck = 1'b0; fixed_lat = -1; req = 4'b0101;
    wait_grant(n);
    chk("mid_rst_ptr", 32'(bus.o_gnt), 32'h1);
    wait_ack(n, a);
    wait_ack(n, a);

    // Randomized traffic against the model
    apply_reset();
    random_mode = 1'b1;
    repeat (3000) @(posedge clk);
    random_mode = 1'b0;
    #2 req = '0;
    repeat (60) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
